// File: rtl/alu_share_ctrl.sv
// Round-robin front-end that time-shares one combinational ALU between two
// requesters and returns each result on a single tagged response channel.
module alu_share_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_mode,
  input  logic [3:0]       req0_select,
  input  logic             req0_cin,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_mode,
  input  logic [3:0]       req1_select,
  input  logic             req1_cin,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_cmp,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_select,
  output logic             alu_mode,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_cmp,

  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. Requesters hold payload stable while valid is high and ready
  // is low; rsp_* are held stable while rsp_valid is high and rsp_ready low.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic               ptr_q;
  logic               gnt_q;
  logic               rsp_valid_q;
  logic               rsp_id_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_cout_q;
  logic               rsp_cmp_q;
  logic [WIDTH-1:0]   alu_a_q;
  logic [WIDTH-1:0]   alu_b_q;
  logic [3:0]         alu_select_q;
  logic               alu_mode_q;
  logic               alu_cin_q;
  logic [CNT_W-1:0]   op_count_q;

  logic [1:0]         req_valid;
  logic               gnt_any;
  logic               gnt_id;
  logic               sel_mode;
  logic [3:0]         sel_select;
  logic               sel_cin;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  assign req_valid = {req1_valid, req0_valid};

  // Pointer-preferred requester wins; grants are suppressed in reset and
  // whenever an operation is already in flight.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = ptr_q;
    if (req_valid[ptr_q]) begin
      gnt_any = 1'b1;
      gnt_id  = ptr_q;
    end else if (req_valid[~ptr_q]) begin
      gnt_any = 1'b1;
      gnt_id  = ~ptr_q;
    end
    if (!rst || state_q != ST_IDLE) begin
      gnt_any = 1'b0;
    end
  end

  assign req0_ready = gnt_any && (gnt_id == 1'b0);
  assign req1_ready = gnt_any && (gnt_id == 1'b1);

  always_comb begin
    sel_mode   = req0_mode;
    sel_select = req0_select;
    sel_cin    = req0_cin;
    sel_a      = req0_a;
    sel_b      = req0_b;
    if (gnt_id) begin
      sel_mode   = req1_mode;
      sel_select = req1_select;
      sel_cin    = req1_cin;
      sel_a      = req1_a;
      sel_b      = req1_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      gnt_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_cmp_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_select_q <= '0;
      alu_mode_q   <= 1'b0;
      alu_cin_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            alu_a_q      <= sel_a;
            alu_b_q      <= sel_b;
            alu_select_q <= sel_select;
            alu_mode_q   <= sel_mode;
            alu_cin_q    <= sel_cin;
            gnt_q        <= gnt_id;
            ptr_q        <= ~gnt_id;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= alu_result;
          rsp_cout_q  <= alu_cout;
          rsp_cmp_q   <= alu_cmp;
          rsp_id_q    <= gnt_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          // Response payload is retained after the handshake; only valid drops.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (op_count_q != {CNT_W{1'b1}}) begin
              op_count_q <= op_count_q + 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_cmp    = rsp_cmp_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_select_q;
  assign alu_mode   = alu_mode_q;
  assign alu_cin    = alu_cin_q;
  assign busy       = (state_q != ST_IDLE);
  assign op_count   = op_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: transaction-level model of arbitration, latency,
// response ordering and the saturating counter (a 2-bit counter copy too).
module tb_alu_share_ctrl;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         v[2];
  logic         md[2];
  logic [3:0]   sl[2];
  logic         ci[2];
  logic [W-1:0] a[2];
  logic [W-1:0] b[2];
  logic         rsp_ready;

  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_cout, rsp_cmp;
  logic [W-1:0] rsp_data;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_select;
  logic         alu_mode, alu_cin, alu_cout, alu_cmp;
  logic         busy;
  logic [15:0]  op_count;
  logic [1:0]   state_dbg;

  logic         s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_cout, s_rsp_cmp;
  logic [W-1:0] s_rsp_data, s_alu_a, s_alu_b, s_alu_result;
  logic [3:0]   s_alu_select;
  logic         s_alu_mode, s_alu_cin, s_alu_cout, s_alu_cmp, s_busy;
  logic [1:0]   s_op_count;
  logic [1:0]   s_state_dbg;

  // Environment ALU: sel 1001 adds, sel 0110 subtracts (mode 1); else logic ops.
  function automatic logic [W+1:0] alu_ref(input logic m, input logic [3:0] s,
                                           input logic c, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [W:0] t;
    t = '0;
    if (!m) begin
      t = {1'b0, (x & y) ^ {12'd0, s}};
    end else begin
      case (s)
        4'b1001: t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        4'b0110: t = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, c};
        default: t = {1'b0, (x ^ y) + {12'd0, s}};
      endcase
    end
    return {t[W], (x == y), t[W-1:0]};
  endfunction

  assign {alu_cout, alu_cmp, alu_result} = alu_ref(alu_mode, alu_select, alu_cin, alu_a, alu_b);
  assign {s_alu_cout, s_alu_cmp, s_alu_result} =
    alu_ref(s_alu_mode, s_alu_select, s_alu_cin, s_alu_a, s_alu_b);

  alu_share_ctrl #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_mode(md[0]), .req0_select(sl[0]),
    .req0_cin(ci[0]), .req0_a(a[0]), .req0_b(b[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_mode(md[1]), .req1_select(sl[1]),
    .req1_cin(ci[1]), .req1_a(a[1]), .req1_b(b[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_cmp(rsp_cmp),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_mode(alu_mode),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout), .alu_cmp(alu_cmp),
    .busy(busy), .op_count(op_count), .state_dbg(state_dbg)
  );

  alu_share_ctrl #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(s_req0_ready), .req0_mode(md[0]), .req0_select(sl[0]),
    .req0_cin(ci[0]), .req0_a(a[0]), .req0_b(b[0]),
    .req1_valid(v[1]), .req1_ready(s_req1_ready), .req1_mode(md[1]), .req1_select(sl[1]),
    .req1_cin(ci[1]), .req1_a(a[1]), .req1_b(b[1]),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
    .rsp_cout(s_rsp_cout), .rsp_cmp(s_rsp_cmp),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_select(s_alu_select), .alu_mode(s_alu_mode),
    .alu_cin(s_alu_cin), .alu_result(s_alu_result), .alu_cout(s_alu_cout), .alu_cmp(s_alu_cmp),
    .busy(s_busy), .op_count(s_op_count), .state_dbg(s_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [W+2:0] exp_q[$];   // {id, cout, cmp, data}
  int           gnt_log[$];
  int           cyc = 0;
  bit           m_pref = 1'b0;
  bit           m_out = 1'b0;
  int           m_hs = 0;
  int unsigned  m_cnt = 0;
  bit           prev_low = 1'b0;
  bit           hs[2];

  // Knobs for the driver.
  bit auto_drv = 1'b0;
  bit contend  = 1'b0;
  int p_valid  = 50;
  int p_drop   = 10;
  int p_rdy    = 70;

  task automatic monitor();
    bit e_any;
    int e_id;
    cyc++;
    hs[0] = 1'b0;
    hs[1] = 1'b0;
    if (!rst) begin
      check_eq("rst_ready0", req0_ready, 0);
      check_eq("rst_ready1", req1_ready, 0);
      if (prev_low) begin
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_op_count", op_count, 0);
        check_eq("rst_sat_count", s_op_count, 0);
      end
      m_pref = 1'b0;
      m_out  = 1'b0;
      m_cnt  = 0;
      exp_q.delete();
      prev_low = 1'b1;
      return;
    end
    prev_low = 1'b0;

    e_any = 1'b0;
    e_id  = 0;
    if (!m_out) begin
      if (v[m_pref]) begin
        e_any = 1'b1; e_id = int'(m_pref);
      end else if (v[!m_pref]) begin
        e_any = 1'b1; e_id = int'(!m_pref);
      end
    end

    check_eq("ready0", req0_ready, (e_any && e_id == 0));
    check_eq("ready1", req1_ready, (e_any && e_id == 1));
    check_eq("busy", busy, m_out);
    check_eq("rsp_valid", rsp_valid, (m_out && (cyc - m_hs) >= 2));
    check_eq("op_count", op_count, (m_cnt > 32'hFFFF) ? 32'hFFFF : m_cnt);
    check_eq("sat_count", s_op_count, (m_cnt > 3) ? 3 : m_cnt);

    if (rsp_valid && exp_q.size() > 0) begin
      check_eq("rsp_payload", {rsp_id, rsp_cout, rsp_cmp, rsp_data}, exp_q[0]);
    end
    if (rsp_valid && rsp_ready && m_out) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_cnt++;
      m_out = 1'b0;
    end

    if (e_any) begin
      hs[e_id] = 1'b1;
      m_out    = 1'b1;
      m_hs     = cyc;
      m_pref   = (e_id == 0);
      gnt_log.push_back(e_id);
      exp_q.push_back({e_id[0], alu_ref(md[e_id], sl[e_id], ci[e_id], a[e_id], b[e_id])});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_payload(input int n);
    logic [3:0] pick;
    pick = 4'($urandom_range(0, 15));
    md[n] = 1'($urandom_range(0, 3) != 0);
    sl[n] = (pick < 6) ? 4'b1001 : (pick < 10) ? 4'b0110 : pick;
    ci[n] = 1'($urandom_range(0, 1));
    a[n]  = W'($urandom);
    b[n]  = ($urandom_range(0, 3) == 0) ? a[n] : W'($urandom);
  endtask

  task automatic drive();
    for (int n = 0; n < 2; n++) begin
      if (contend) begin
        if (hs[n]) new_payload(n);
        v[n] = 1'b1;
      end else if (auto_drv) begin
        if (hs[n]) begin
          new_payload(n);
          v[n] = ($urandom_range(0, 99) < p_valid);
        end else if (v[n]) begin
          if ($urandom_range(0, 99) < p_drop) v[n] = 1'b0;
        end else if ($urandom_range(0, 99) < p_valid) begin
          new_payload(n);
          v[n] = 1'b1;
        end
      end else if (hs[n]) begin
        v[n] = 1'b0;
      end
    end
    if (auto_drv) rsp_ready = ($urandom_range(0, 99) < p_rdy);
  endtask

  // One clock: check at the falling edge, drive just after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) step();
    check_eq("idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  logic [W+2:0] snap;
  int unsigned  c0;

  initial begin
    rst = 1'b0;
    rsp_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      new_payload(n);
      v[n] = 1'b1;
    end
    #1;

    // Reset with both valids high.
    step();
    step();
    check_eq("reset_ready0", req0_ready, 0);
    check_eq("reset_ready1", req1_ready, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_alu_a", alu_a, 0);
    check_eq("reset_rsp_data", rsp_data, 0);
    rst = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check_eq("first_grant0", req0_ready, 1);
    check_eq("first_grant1", req1_ready, 0);
    for (int i = 0; i < 8; i++) step();
    wait_idle();

    // Single directed op: 0x1234 + 0x00FF.
    v[0] = 1'b0; v[1] = 1'b0;
    md[0] = 1'b1; sl[0] = 4'b1001; ci[0] = 1'b0; a[0] = 16'h1234; b[0] = 16'h00FF;
    v[0] = 1'b1;
    c0 = m_cnt;
    #1;
    check_eq("single_ready0", req0_ready, 1);
    step();
    step();
    check_eq("single_rsp_valid", rsp_valid, 1);
    check_eq("single_rsp_data", rsp_data, 16'h1333);
    check_eq("single_rsp_id", rsp_id, 0);
    step();
    check_eq("single_op_count", op_count, c0 + 1);
    check_eq("single_rsp_clr", rsp_valid, 0);

    // Contention: both valid continuously.
    gnt_log.delete();
    contend = 1'b1;
    v[0] = 1'b1; v[1] = 1'b1;
    for (int i = 0; i < 63; i++) step();
    check_eq("contend_ops", (gnt_log.size() >= 20), 1);
    for (int i = 1; i < gnt_log.size(); i++) begin
      check_eq("contend_alt", gnt_log[i], gnt_log[i-1] ^ 1);
    end

    // Backpressure for 5 cycles.
    rsp_ready = 1'b0;
    for (int i = 0; i < 6 && !rsp_valid; i++) step();
    check_eq("bp_rsp_valid", rsp_valid, 1);
    snap = {rsp_id, rsp_cout, rsp_cmp, rsp_data};
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_hold", {rsp_id, rsp_cout, rsp_cmp, rsp_data}, snap);
      check_eq("bp_noready", {req0_ready, req1_ready}, 0);
      check_eq("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    step();
    check_eq("bp_next_grant", req0_ready ^ req1_ready, 1);
    contend = 1'b0;
    step();
    v[0] = 1'b0; v[1] = 1'b0;
    wait_idle();

    // Reset during EXEC after req0 moved the pointer to req1.
    v[0] = 1'b1;
    step();
    check_eq("mid_exec_busy", busy, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("mid_no_rsp", rsp_valid, 0);
      check_eq("mid_op_count", op_count, 0);
    end
    v[0] = 1'b1; v[1] = 1'b1;
    #1;
    check_eq("mid_ptr0_ready0", req0_ready, 1);
    check_eq("mid_ptr0_ready1", req1_ready, 0);
    for (int i = 0; i < 8; i++) step();

    // Random traffic; also drives the 2-bit counter copy into saturation.
    auto_drv = 1'b1;
    for (int i = 0; i < 400; i++) step();
    check_eq("sat_min_ops", (m_cnt >= 5), 1);
    check_eq("sat_hold", s_op_count, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
